// File: rtl/mem_stage.sv
// mem_stage -- data-memory stage fed by the ALU stage.
//
// Performs one word or byte load/store per request on an internal RAM. Each
// request runs IDLE -> WAIT (WAIT_STATES cycles) -> ACCESS -> DONE, with a
// Start/Busy/Done handshake toward the control unit. The request is latched
// on acceptance, so the ALU/RF inputs may change while the access is pending.
//
// Ports
//   Clk           in   1   clock, rising edge
//   Reset         in   1   asynchronous, active-high reset
//   Start         in   1   request pulse, only sampled in IDLE
//   MEM_WrEn      in   1   store request (qualified by Start)
//   MEM_RdEn      in   1   load request (qualified by Start)
//   ByteOp        in   1   1 = byte access, 0 = word access
//   ALU_MEM_Addr  in   32  byte address
//   MEM_DataIn    in   32  store data
//   MEM_DataOut   out  32  load result, held until the next access completes
//   Busy          out  1   high in WAIT and ACCESS
//   Done          out  1   one-cycle completion pulse
//   Err           out  1   valid with Done: misaligned or out-of-range access
module mem_stage #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h400,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        MEM_WrEn,
    input  logic        MEM_RdEn,
    input  logic        ByteOp,
    input  logic [31:0] ALU_MEM_Addr,
    input  logic [31:0] MEM_DataIn,
    output logic [31:0] MEM_DataOut,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        accept;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        wr_q;
    logic        byte_q;

    logic [31:0] off;
    logic [AW-1:0] idx;
    logic [1:0]  lane;
    logic        acc_err;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        err_q;

    logic [31:0] ram [DEPTH];

    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic        bop,
                                                 input logic [1:0]  ln);
        if (bop)
            return {24'b0, w[8*ln +: 8]};
        return w;
    endfunction

    // A request is taken only with exactly one of the two enables set.
    assign accept = (state == S_IDLE) && Start && (MEM_WrEn ^ MEM_RdEn);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'(WAIT_STATES - 1))
                    state_nxt = S_ACCESS;
                else
                    wait_cnt_nxt = wait_cnt + 4'd1;
            end
            S_ACCESS: state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign Busy = (state == S_WAIT) || (state == S_ACCESS);
    assign Done = (state == S_DONE);
    assign Err  = Done && err_q;

    // Request latch: data path only, no reset needed.
    always_ff @(posedge Clk) begin
        if (accept) begin
            addr_q <= ALU_MEM_Addr;
            data_q <= MEM_DataIn;
            wr_q   <= MEM_WrEn;
            byte_q <= ByteOp;
        end
    end

    // Address decode. The subtraction wraps for addresses below BASE_ADDR,
    // which the explicit compare catches independently of the wrap.
    always_comb begin
        off     = addr_q - BASE_ADDR;
        lane    = off[1:0];
        idx     = off[AW+1:2];
        acc_err = (addr_q < BASE_ADDR) || (off >= SPAN) || (!byte_q && (lane != 2'd0));
        be      = byte_q ? (4'b0001 << lane) : 4'b1111;
        wdata   = byte_q ? {4{data_q[7:0]}} : data_q;
    end

    // Store commits on the closing edge of ACCESS only; an async reset
    // before that edge leaves the RAM untouched.
    always_ff @(posedge Clk) begin
        if ((state == S_ACCESS) && wr_q && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    ram[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Load result and error flag, registered on the closing edge of ACCESS.
    // Successful stores leave MEM_DataOut untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MEM_DataOut <= '0;
            err_q       <= 1'b0;
        end else if (state == S_ACCESS) begin
            err_q <= acc_err;
            if (acc_err)
                MEM_DataOut <= '0;
            else if (!wr_q)
                MEM_DataOut <= load_extract(ram[idx], byte_q, lane);
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start0, Start1;
    logic        MEM_WrEn, MEM_RdEn, ByteOp;
    logic [31:0] ALU_MEM_Addr, MEM_DataIn;
    logic [31:0] dout0, dout1;
    logic        busy0, busy1, done0, done1, err0, err1;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mem_stage #(.DEPTH(1024), .BASE_ADDR(32'h400), .WAIT_STATES(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start0), .MEM_WrEn(MEM_WrEn),
        .MEM_RdEn(MEM_RdEn), .ByteOp(ByteOp), .ALU_MEM_Addr(ALU_MEM_Addr),
        .MEM_DataIn(MEM_DataIn), .MEM_DataOut(dout0), .Busy(busy0),
        .Done(done0), .Err(err0)
    );

    mem_stage #(.DEPTH(16), .BASE_ADDR(32'h400), .WAIT_STATES(0)) dut1 (
        .Clk(Clk), .Reset(Reset), .Start(Start1), .MEM_WrEn(MEM_WrEn),
        .MEM_RdEn(MEM_RdEn), .ByteOp(ByteOp), .ALU_MEM_Addr(ALU_MEM_Addr),
        .MEM_DataIn(MEM_DataIn), .MEM_DataOut(dout1), .Busy(busy1),
        .Done(done1), .Err(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete request: Start in cycle 0, inputs scrambled from cycle 1,
    // Busy expected in cycles 1..W+1 and Done in cycle W+2.
    task automatic run_op(input int sel, input logic wr, input logic bop,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] dout, output logic err);
        int w;
        int done_cyc;
        logic busy_bad;
        logic sb, sd;
        w        = (sel == 0) ? 2 : 0;
        done_cyc = 0;
        busy_bad = 1'b0;
        dout     = 'x;
        err      = 1'bx;
        @(negedge Clk);
        MEM_WrEn     = wr;
        MEM_RdEn     = ~wr;
        ByteOp       = bop;
        ALU_MEM_Addr = addr;
        MEM_DataIn   = data;
        if (sel == 0) Start0 = 1'b1; else Start1 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            #1;
            if (k == 1) begin
                Start0       = 1'b0;
                Start1       = 1'b0;
                ALU_MEM_Addr = $urandom;
                MEM_DataIn   = $urandom;
                ByteOp       = ~bop;
                MEM_WrEn     = ~wr;
                MEM_RdEn     = wr;
            end
            @(negedge Clk);
            sb = (sel == 0) ? busy0 : busy1;
            sd = (sel == 0) ? done0 : done1;
            if (sb !== ((k <= w + 1) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
            if (sd === 1'b1) begin
                done_cyc = k;
                dout     = (sel == 0) ? dout0 : dout1;
                err      = (sel == 0) ? err0 : err1;
                break;
            end
        end
        chk("done_cycle", done_cyc, w + 2);
        chk("busy_window", {31'b0, busy_bad}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic        bop;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mkv(input logic wr, input logic bop, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.wr = wr; v.bop = bop; v.addr = addr; v.data = data;
        v.exp_dout = ed; v.exp_err = ee;
        return v;
    endfunction

    // Reference byte image of the first 64 bytes above BASE_ADDR.
    logic [7:0]  mb [64];
    logic [31:0] last_dout;

    task automatic model_op(input logic wr, input logic bop, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] ed, output logic ee);
        logic [31:0] off;
        off = addr - 32'h400;
        ee  = (addr < 32'h400) || (off >= 32'd4096) || (!bop && (off % 4 != 0));
        if (ee) begin
            ed = 32'd0;
        end else if (wr) begin
            if (bop) mb[off] = data[7:0];
            else for (int i = 0; i < 4; i++) mb[off + i] = data[8*i +: 8];
            ed = last_dout;
        end else if (bop) begin
            ed = {24'd0, mb[off]};
        end else begin
            ed = {mb[off + 3], mb[off + 2], mb[off + 1], mb[off]};
        end
        last_dout = ed;
    endtask

    vec_t        tbl [17];
    logic [31:0] d;
    logic        e;
    logic        flag;
    int          ndone;

    initial begin
        Reset = 1'b1; Start0 = 1'b0; Start1 = 1'b0;
        MEM_WrEn = 1'b0; MEM_RdEn = 1'b0; ByteOp = 1'b0;
        ALU_MEM_Addr = '0; MEM_DataIn = '0;

        tbl[0]  = mkv(1, 0, 32'h404,  32'hDEADBEEF, 32'h00000000, 0);
        tbl[1]  = mkv(0, 0, 32'h404,  32'h0,        32'hDEADBEEF, 0);
        tbl[2]  = mkv(1, 0, 32'h404,  32'h11223344, 32'hDEADBEEF, 0);
        tbl[3]  = mkv(1, 1, 32'h406,  32'hFFFFFFAA, 32'hDEADBEEF, 0);
        tbl[4]  = mkv(0, 0, 32'h404,  32'h0,        32'h11AA3344, 0);
        tbl[5]  = mkv(0, 1, 32'h406,  32'h0,        32'h000000AA, 0);
        tbl[6]  = mkv(0, 1, 32'h407,  32'h0,        32'h00000011, 0);
        tbl[7]  = mkv(0, 1, 32'h404,  32'h0,        32'h00000044, 0);
        tbl[8]  = mkv(0, 0, 32'h405,  32'h0,        32'h00000000, 1);
        tbl[9]  = mkv(1, 0, 32'h3FC,  32'h12345678, 32'h00000000, 1);
        tbl[10] = mkv(1, 0, 32'h1400, 32'h12345678, 32'h00000000, 1);
        tbl[11] = mkv(0, 0, 32'h404,  32'h0,        32'h11AA3344, 0);
        tbl[12] = mkv(1, 0, 32'h408,  32'hCAFEF00D, 32'h11AA3344, 0);
        tbl[13] = mkv(1, 1, 32'h13FF, 32'h00000077, 32'h11AA3344, 0);
        tbl[14] = mkv(0, 1, 32'h13FF, 32'h0,        32'h00000077, 0);
        tbl[15] = mkv(0, 0, 32'h3FF,  32'h0,        32'h00000000, 1);
        tbl[16] = mkv(0, 1, 32'h3FF,  32'h0,        32'h00000000, 1);

        #12;
        chk("rst_dout", dout0, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        chk("rst_err",  {31'b0, err0},  32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op(0, tbl[i].wr, tbl[i].bop, tbl[i].addr, tbl[i].data, d, e);
            chk($sformatf("tbl%0d_dout", i), d, tbl[i].exp_dout);
            chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
        end

        // Start with both or neither enable is ignored.
        for (int p = 0; p < 2; p++) begin
            flag = 1'b0;
            @(negedge Clk);
            MEM_WrEn = (p == 0); MEM_RdEn = (p == 0); Start0 = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                @(posedge Clk); #1;
                if (k == 1) Start0 = 1'b0;
                @(negedge Clk);
                if (busy0 !== 1'b0 || done0 !== 1'b0) flag = 1'b1;
            end
            chk($sformatf("bad_enables%0d_ignored", p), {31'b0, flag}, 32'd0);
        end

        // Start held during WAIT/ACCESS with a different request: ignored.
        ndone = 0;
        @(negedge Clk);
        MEM_WrEn = 1'b1; MEM_RdEn = 1'b0; ByteOp = 1'b0;
        ALU_MEM_Addr = 32'h40C; MEM_DataIn = 32'h00000099; Start0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge Clk); #1;
            if (k == 1) begin
                MEM_WrEn = 1'b0; MEM_RdEn = 1'b1; ALU_MEM_Addr = 32'h404;
                MEM_DataIn = 32'hFFFFFFFF;
            end
            if (k == 4) Start0 = 1'b0;
            @(negedge Clk);
            if (done0 === 1'b1) ndone++;
        end
        chk("busy_start_one_done", ndone, 1);
        run_op(0, 0, 0, 32'h40C, 32'h0, d, e);
        chk("busy_start_store_kept", d, 32'h00000099);

        // Async reset during WAIT of a store aborts it.
        run_op(0, 0, 0, 32'h404, 32'h0, d, e);
        chk("pre_reset_load", d, 32'h11AA3344);
        @(negedge Clk);
        MEM_WrEn = 1'b1; MEM_RdEn = 1'b0; ByteOp = 1'b0;
        ALU_MEM_Addr = 32'h408; MEM_DataIn = 32'h00000055; Start0 = 1'b1;
        @(posedge Clk); #1;
        Start0 = 1'b0;
        #1;
        chk("wait_busy_before_reset", {31'b0, busy0}, 32'd1);
        Reset = 1'b1;
        #1;
        chk("async_rst_dout", dout0, 32'd0);
        chk("async_rst_busy", {31'b0, busy0}, 32'd0);
        chk("async_rst_done", {31'b0, done0}, 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        run_op(0, 0, 0, 32'h408, 32'h0, d, e);
        chk("aborted_store_0x408", d, 32'hCAFEF00D);
        run_op(0, 0, 0, 32'h404, 32'h0, d, e);
        chk("intact_0x404", d, 32'h11AA3344);

        // Randomised traffic against the byte-image model.
        last_dout = d;
        for (int w = 0; w < 16; w++) begin
            logic [31:0] r;
            logic [31:0] ed;
            logic        ee;
            r = $urandom;
            model_op(1, 0, 32'h400 + 32'(4 * w), r, ed, ee);
            run_op(0, 1, 0, 32'h400 + 32'(4 * w), r, d, e);
            chk("init_err", {31'b0, e}, {31'b0, ee});
        end
        for (int n = 0; n < 60; n++) begin
            logic        wr, bop;
            logic [31:0] a, r, ed;
            logic        ee;
            int          sel;
            wr  = $urandom_range(0, 1) == 1;
            bop = $urandom_range(0, 1) == 1;
            r   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h400 - 32'($urandom_range(1, 16));
            else if (sel == 1) a = 32'h1400 + 32'($urandom_range(0, 15));
            else if (sel == 2) a = 32'hFFFFFFFC;
            else               a = 32'h400 + 32'($urandom_range(0, 63));
            model_op(wr, bop, a, r, ed, ee);
            run_op(0, wr, bop, a, r, d, e);
            chk($sformatf("rnd%0d_dout", n), d, ed);
            chk($sformatf("rnd%0d_err", n), {31'b0, e}, {31'b0, ee});
        end

        // Zero-wait-state build, back-to-back requests.
        run_op(1, 1, 0, 32'h404, 32'h0BADC0DE, d, e);
        chk("w0_store_err", {31'b0, e}, 32'd0);
        run_op(1, 0, 0, 32'h404, 32'h0, d, e);
        chk("w0_load", d, 32'h0BADC0DE);
        run_op(1, 1, 1, 32'h405, 32'h0000005A, d, e);
        run_op(1, 0, 0, 32'h404, 32'h0, d, e);
        chk("w0_sb_lw", d, 32'h0BAD5ADE);
        run_op(1, 0, 1, 32'h43F, 32'h0, d, e);
        chk("w0_last_byte_err", {31'b0, e}, 32'd0);
        run_op(1, 0, 0, 32'h440, 32'h0, d, e);
        chk("w0_range_err", {31'b0, e}, 32'd1);
        chk("w0_range_dout", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
